// File: rtl/misao_alu_serial.sv
// rtl/misao_alu_serial.sv - slice-serial MISA-O ALU: one SLICE_W slice per clock, chained carry/shift bit
module misao_alu_serial #(
    parameter int SLICE_W = 4,
    parameter int NSLICE  = 4,
    parameter int LEN_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1,
    localparam int DATA_W = SLICE_W * NSLICE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [3:0]        op_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              carry_en_i,
    input  logic              cin_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              cout_o,
    output logic              zero_o
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_INC = 4'd2, OP_DEC = 4'd3,
                           OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_INV = 4'd7,
                           OP_SHL = 4'd8, OP_SHR = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, b_q, result_q, result_d;
    logic [3:0]          op_q;
    logic [LEN_W-1:0]    lm1_q, cnt_q, idx_q, lm1_in;
    logic                c_q, c_n, cout_q, zero_q, last_slice;
    logic [SLICE_W-1:0]  a_s, b_s, s;
    logic [SLICE_W:0]    sum;

    // Requested length is clamped so the slice index never leaves the operand.
    assign lm1_in = (int'(len_i) >= NSLICE) ? LEN_W'(NSLICE - 1) : len_i;

    always_comb begin
        state_d    = state_q;
        a_s        = a_q[idx_q*SLICE_W +: SLICE_W];
        b_s        = b_q[idx_q*SLICE_W +: SLICE_W];
        sum        = '0;
        s          = '0;
        c_n        = 1'b0;
        last_slice = (cnt_q == lm1_q);
        case (op_q)
            OP_ADD: begin
                sum = {1'b0, a_s} + {1'b0, b_s} + {{SLICE_W{1'b0}}, c_q};
                s   = sum[SLICE_W-1:0];
                c_n = sum[SLICE_W];
            end
            OP_SUB: begin
                sum = {1'b0, a_s} - {1'b0, b_s} - {{SLICE_W{1'b0}}, c_q};
                s   = sum[SLICE_W-1:0];
                c_n = sum[SLICE_W];
            end
            OP_INC: begin
                sum = {1'b0, a_s} + {{SLICE_W{1'b0}}, c_q};
                s   = sum[SLICE_W-1:0];
                c_n = sum[SLICE_W];
            end
            OP_DEC: begin
                sum = {1'b0, a_s} - {{SLICE_W{1'b0}}, c_q};
                s   = sum[SLICE_W-1:0];
                c_n = sum[SLICE_W];
            end
            OP_AND: s = a_s & b_s;
            OP_OR:  s = a_s | b_s;
            OP_XOR: s = a_s ^ b_s;
            OP_INV: s = ~a_s;
            OP_SHL: begin
                sum = {a_s, c_q};
                s   = sum[SLICE_W-1:0];
                c_n = sum[SLICE_W];
            end
            OP_SHR: begin
                sum = {c_q, a_s};
                s   = sum[SLICE_W:1];
                c_n = sum[0];
            end
            default: s = a_s;
        endcase
        result_d = result_q;
        result_d[idx_q*SLICE_W +: SLICE_W] = s;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            lm1_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (start_i) begin
                    a_q      <= a_i;
                    b_q      <= b_i;
                    op_q     <= op_i;
                    lm1_q    <= lm1_in;
                    cnt_q    <= '0;
                    idx_q    <= (op_i == OP_SHR) ? lm1_in : '0;
                    c_q      <= (op_i == OP_INC || op_i == OP_DEC) ? 1'b1 : (carry_en_i & cin_i);
                    result_q <= '0;
                    cout_q   <= 1'b0;
                    zero_q   <= 1'b0;
                end
                S_RUN: begin
                    result_q <= result_d;
                    c_q      <= c_n;
                    cnt_q    <= cnt_q + 1'b1;
                    idx_q    <= (op_q == OP_SHR) ? idx_q - 1'b1 : idx_q + 1'b1;
                    if (last_slice) begin
                        cout_q <= c_n;
                        zero_q <= (result_d == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (state_q == S_RUN) || (state_q == S_DONE);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign zero_o   = zero_q;
endmodule

// File: tb/tb_misao_alu_serial.sv
// tb/tb_misao_alu_serial.sv - self-checking bench for misao_alu_serial
module tb_misao_alu_serial;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  op_i = '0;
    logic [1:0]  len_i = '0;
    logic        carry_en_i = 1'b0;
    logic        cin_i = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        busy_o, done_o, cout_o, zero_o;
    logic [15:0] result_o;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        logic [15:0] r;
        logic        co;
        logic        z;
        int          acc;
        int          len;
    } exp_t;
    exp_t exp_q[$];

    misao_alu_serial dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .len_i(len_i),
        .carry_en_i(carry_en_i), .cin_i(cin_i), .a_i(a_i), .b_i(b_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .cout_o(cout_o), .zero_o(zero_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Whole-operand arithmetic over the active width L*4 bits.
    function automatic void model(input logic [3:0] op, input int len, input logic cin,
                                  input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic co);
        longint w  = longint'(len * 4);
        longint m  = (longint'(1) << w) - 1;
        longint am = longint'(a) & m;
        longint bm = longint'(b) & m;
        longint cl = longint'(cin);
        longint t;
        co = 1'b0;
        case (op)
            4'd0: begin t = am + bm + cl; co = (t > m); end
            4'd1: begin t = am - bm - cl; co = (t < 0); end
            4'd2: begin t = am + 1;       co = (t > m); end
            4'd3: begin t = am - 1;       co = (t < 0); end
            4'd4: t = am & bm;
            4'd5: t = am | bm;
            4'd6: t = am ^ bm;
            4'd7: t = ~am;
            4'd8: begin t = (am << 1) | cl; co = (t > m); end
            4'd9: begin t = (am >> 1) | (cl << (w - 1)); co = a[0]; end
            default: t = am;
        endcase
        t = t & m;
        r = t[15:0];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", 32'(busy_o), 32'd0);
            chk("rst_done", 32'(done_o), 32'd0);
            chk("rst_result", 32'(result_o), 32'd0);
            chk("rst_cout", 32'(cout_o), 32'd0);
            chk("rst_zero", 32'(zero_o), 32'd0);
        end else if (done_o) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("model_result", 32'(result_o), 32'(e.r));
                chk("model_cout", 32'(cout_o), 32'(e.co));
                chk("model_zero", 32'(zero_o), 32'(e.z));
                chk("latency", 32'(edge_cnt - e.acc), 32'(e.len));
                chk("busy_in_done", 32'(busy_o), 32'd1);
            end
        end
    end

    task automatic push_exp(input logic [3:0] op, input logic [1:0] len, input logic cen,
                            input logic cin, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.len = int'(len) + 1;
        model(op, e.len, cen & cin, a, b, e.r, e.co);
        e.z   = (e.r == 16'h0);
        e.acc = edge_cnt;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] len, input logic cen,
                         input logic cin, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        op_i = op; len_i = len; carry_en_i = cen; cin_i = cin; a_i = a; b_i = b;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        push_exp(op, len, cen, cin, a, b);
        chk("busy_after_accept", 32'(busy_o), 32'd1);
        a_i = ~a; b_i = ~b; op_i = 4'd15; cin_i = ~cin;
    endtask

    task automatic wait_done(input int snap);
        int n = 0;
        while (done_cnt == snap && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", 32'(done_cnt - snap), 32'd1);
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [1:0] len,
                       input logic cen, input logic cin, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic eco, input logic ez);
        int snap = done_cnt;
        issue(op, len, cen, cin, a, b);
        wait_done(snap);
        #1;
        chk({name, "_result"}, 32'(result_o), 32'(er));
        chk({name, "_cout"}, 32'(cout_o), 32'(eco));
        chk({name, "_zero"}, 32'(zero_o), 32'(ez));
        chk({name, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int snap;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run("sub_l1_a",   4'd1, 2'd0, 1'b1, 1'b0, 16'h0009, 16'h0003, 16'h0006, 1'b0, 1'b0);
        run("sub_l1_b",   4'd1, 2'd0, 1'b1, 1'b0, 16'h0006, 16'h0003, 16'h0003, 1'b0, 1'b0);
        run("add_l2",     4'd0, 2'd1, 1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0000, 1'b1, 1'b1);
        run("add_l2_cin", 4'd0, 2'd1, 1'b1, 1'b1, 16'h00FF, 16'h0001, 16'h0001, 1'b1, 1'b0);
        run("sub_l4_a",   4'd1, 2'd3, 1'b0, 1'b0, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0);
        run("sub_l4_b",   4'd1, 2'd3, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
        run("shr_l4",     4'd9, 2'd3, 1'b1, 1'b1, 16'h8001, 16'h0000, 16'hC000, 1'b1, 1'b0);
        run("shl_l2",     4'd8, 2'd1, 1'b0, 1'b1, 16'h0081, 16'h0000, 16'h0002, 1'b1, 1'b0);
        run("xor_l2",     4'd6, 2'd1, 1'b0, 1'b0, 16'hABCD, 16'h00FF, 16'h0032, 1'b0, 1'b0);
        run("inv_l1",     4'd7, 2'd0, 1'b1, 1'b1, 16'h1235, 16'h0000, 16'h000A, 1'b0, 1'b0);
        run("pass_l3",    4'd12, 2'd2, 1'b0, 1'b0, 16'h1234, 16'hFFFF, 16'h0234, 1'b0, 1'b0);
        run("add_nocen",  4'd0, 2'd3, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
        run("shr_l1",     4'd9, 2'd0, 1'b1, 1'b1, 16'hFFF2, 16'h0000, 16'h0009, 1'b0, 1'b0);

        // start_i held high for the whole INC: only the first request may be taken.
        snap = done_cnt;
        @(negedge clk);
        op_i = 4'd2; len_i = 2'd3; carry_en_i = 1'b0; cin_i = 1'b0; a_i = 16'h00FF; b_i = 16'h0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        push_exp(4'd2, 2'd3, 1'b0, 1'b0, 16'h00FF, 16'h0);
        a_i = 16'h7777;
        begin
            int n = 0;
            while (done_cnt == snap && n < 40) begin
                @(posedge clk);
                n++;
            end
        end
        #1;
        start_i = 1'b0;
        chk("inc_result", 32'(result_o), 32'h0100);
        chk("inc_cout", 32'(cout_o), 32'd0);
        repeat (8) @(posedge clk);
        chk("inc_single_done", 32'(done_cnt - snap), 32'd1);

        // Reset in the second RUN cycle aborts without a done pulse.
        issue(4'd0, 2'd3, 1'b0, 1'b0, 16'h1111, 16'h2222);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_result", 32'(result_o), 32'd0);
        snap = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        chk("abort_no_done", 32'(done_cnt - snap), 32'd0);
        run("dec_l1", 4'd3, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h000F, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/misao_alu_serial.md
Name: misao_alu_serial

Overview:
- Parametrised multi-slice successor to the MISA-O 4-bit ALU datapath.
- Executes the ALU opcode set (ADD/SUB/INC/DEC/AND/OR/XOR/INV/SHL/SHR) on operands up to SLICE_W*NSLICE bits, one SLICE_W slice per clock.
- Carry/borrow and shift bits chain between slices.
- Lets the core run nibble, byte or word operations through one narrow adder, selected at run time by a length field, with a start/busy/done handshake.

Parameters:
- SLICE_W, 4, width of one slice processed per cycle.
- NSLICE, 4, maximum slices per operation; DATA_W = SLICE_W*NSLICE.
- LEN_W, $clog2(NSLICE) (min 1), width of len_i.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request; accepted only in IDLE.
- op_i  in  4  operation: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 INV, 8 SHL, 9 SHR, 10-15 PASS (result=a).
- len_i  in  LEN_W  active slices minus 1 (L = len_i+1); values >= NSLICE clamp to NSLICE.
- carry_en_i  in  1  1: cin_i participates; 0: treated as 0.
- cin_i  in  1  carry-in / borrow-in / shift-in bit.
- a_i  in  DATA_W  operand A (ACC).
- b_i  in  DATA_W  operand B (RS).
- busy_o  out  1  high in RUN and DONE.
- done_o  out  1  one-cycle pulse; result valid.
- result_o  out  DATA_W  result; slices above L are 0.
- cout_o  out  1  carry/borrow/shifted-out bit.
- zero_o  out  1  all active result bits zero.

Behaviour:
- Reset (async, any state): state=IDLE; busy_o, done_o, cout_o, zero_o = 0; result_o = 0; internal operand/carry registers cleared. No partial result survives.
- States:
  - IDLE: on edge with start_i=1, latch a_i, b_i, op_i, L, cin_eff = carry_en_i & cin_i. Clear the result register. Set the slice index to 0 (NSLICE-1 down for SHR: start at slice L-1). Go to RUN.
  - RUN: each edge computes one slice, writes it into result, updates the chain bit, steps the index. After the L-th slice edge, go to DONE.
  - DONE: done_o=1 for exactly one cycle. Next edge goes to IDLE.
- Latency: start accepted at edge k → done_o high in the cycle after edge k+L. Throughput: one op per L+2 cycles.
- start_i is ignored while busy_o=1, including in DONE. Latched operands are unaffected by input changes after acceptance.
- result_o, cout_o, zero_o hold their values from the DONE cycle until the next accepted start. result_o is cleared at acceptance.
- Arithmetic, per slice, chain register c initialised to cin_eff except INC/DEC:
  - ADD: s = a + b + c, c = carry-out.
  - SUB: s = a - b - c, c = borrow-out.
  - INC: c initialised to 1; s = a + c.
  - DEC: c initialised to 1; s = a - c (borrow).
  - AND/OR/XOR: bitwise. INV: ~a. PASS: a. For all of these cout_o = 0.
- Shifts, one bit over the full L*SLICE_W operand:
  - SHL: processed LSB slice first. Shift-in bit at bit 0 = cin_eff. Each slice's MSB chains to the next slice's LSB. cout_o = MSB of active operand.
  - SHR: processed MSB slice (L-1) first, descending. Shift-in at top active bit = cin_eff. cout_o = bit 0 of a.
- cout_o = final chain value after the last active slice.
- Boundaries:
  - L=1 behaves as the legacy 4-bit ALU.
  - L=NSLICE uses the full width.
  - Wrap-around is modulo 2^(L*SLICE_W).
  - Operand bits above the active width are ignored.
- Reset asserted mid-RUN aborts the operation: no done_o pulse, outputs 0. First start after reset release behaves normally.

Test Plan:
- SUB, L=1, carry_en=1, cin=0, a=0x9, b=0x3 → result=0x0006, cout=0, zero=0; done_o in the 2nd cycle after acceptance. Repeat with a=0x6 → 0x0003.
- ADD, L=2, a=0x00FF, b=0x0001, cin=0 → result=0x0000, cout=1, zero=1; done_o exactly 3 cycles after the accept edge. Repeat with carry_en=1, cin=1 → result=0x0001, zero=0.
- SUB, L=4, a=0x1000, b=0x0001 → 0x0FFF, cout=0. Then a=0x0000, b=0x0001 → 0xFFFF, cout=1 (borrow across all slices).
- SHR, L=4, a=0x8001, carry_en=1, cin=1 → 0xC000, cout=1.
- SHL, L=2, a=0x0081, carry_en=0 → 0x0002, cout=1.
- Pulse start_i every cycle during an L=4 INC of 0x00FF → exactly one done_o, result 0x0100.
- Assert rst in the 2nd RUN cycle → busy_o, done_o, result_o = 0 immediately; no done_o pulse. Next DEC, L=1, a=0x0 → 0x000F, cout=1.
